// File: rtl/l3c_fifo_pop_ctrl.sv
// Per-lane pop sequencer: a request loads a count, then one pop is issued per cycle while the FIFO is non-empty and the PE is ready.
// The first pop can occur one cycle after the request. An empty FIFO or a not-ready PE stalls the lane with its count held.
module l3c_fifo_pop_ctrl #(
  parameter int NUM_FIFO = 32,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_FIFO-1:0] need_pop_matrix_i,
  input  logic [CNT_W-1:0]    pop_num_matrix_i [NUM_FIFO],
  input  logic [NUM_FIFO-1:0] fifo_empty_i,
  input  logic [NUM_FIFO-1:0] pe_ready_i,
  output logic [NUM_FIFO-1:0] fifo_pop_o,
  output logic [NUM_FIFO-1:0] fifo_done_matrix_o,
  output logic                all_done_o,
  output logic                busy_o,
  output logic                protocol_err_o
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_POP  = 1'b1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_FIFO-1:0] in_pop;
  logic [NUM_FIFO-1:0] req_err;
  logic                protocol_err_q;

  for (genvar k = 0; k < NUM_FIFO; k++) begin : g_lane
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             done_q;

    assign in_pop[k]             = (state_q == ST_POP);
    // The remain guard keeps a pop from ever being issued against a zero count.
    assign fifo_pop_o[k]         = in_pop[k] && !fifo_empty_i[k] && pe_ready_i[k] && (remain_q != '0);
    assign req_err[k]            = in_pop[k] && need_pop_matrix_i[k];
    assign fifo_done_matrix_o[k] = done_q;

    always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      if (state_q == ST_IDLE) begin
        if (need_pop_matrix_i[k] && (pop_num_matrix_i[k] != '0)) begin
          state_d  = ST_POP;
          remain_d = pop_num_matrix_i[k];
        end
      end else if (fifo_pop_o[k]) begin
        remain_d = remain_q - ONE;
        if (remain_q == ONE) begin
          state_d = ST_IDLE;
        end
      end
    end

    // done is registered from the next state so it drops in the cycle after an accepted request.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        remain_q <= '0;
        done_q   <= 1'b1;
      end else begin
        state_q  <= state_d;
        remain_q <= remain_d;
        done_q   <= (state_d == ST_IDLE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err_q <= 1'b0;
    end else if (|req_err) begin
      protocol_err_q <= 1'b1;
    end
  end

  assign protocol_err_o = protocol_err_q;
  assign all_done_o     = &fifo_done_matrix_o;
  assign busy_o         = |in_pop;

endmodule

// File: tb/tb_l3c_fifo_pop_ctrl.sv
// Directed scenarios plus randomized traffic, checked against a per-lane outstanding-count model.
module tb_l3c_fifo_pop_ctrl;
  localparam int N = 32;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  need;
  logic [W-1:0]  num [N];
  logic [N-1:0]  empty;
  logic [N-1:0]  ready;
  logic [N-1:0]  pop;
  logic [N-1:0]  done;
  logic          all_done;
  logic          busy;
  logic          perr;

  l3c_fifo_pop_ctrl #(.NUM_FIFO(N), .CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .need_pop_matrix_i(need), .pop_num_matrix_i(num),
    .fifo_empty_i(empty), .pe_ready_i(ready),
    .fifo_pop_o(pop), .fifo_done_matrix_o(done),
    .all_done_o(all_done), .busy_o(busy), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: outstanding pops per lane (0 = idle) and the sticky error bit.
  longint unsigned rem [N];
  bit              m_err;
  int              pop_cnt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        rem[k] = 0;
      end else if (rem[k] > 0) begin
        if (need[k]) m_err = 1'b1;
        if (!empty[k] && ready[k]) rem[k] = rem[k] - 1;
      end else if (need[k] && num[k] != 0) begin
        rem[k] = longint'(num[k]);
      end
    end
    if (rst) m_err = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] e_pop, e_done;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      e_pop[k]  = (rem[k] > 0) && !empty[k] && ready[k];
      e_done[k] = (rem[k] == 0);
    end
    chk("fifo_pop", 64'(pop), 64'(e_pop));
    chk("done", 64'(done), 64'(e_done));
    chk("all_done", 64'(all_done), 64'(&e_done));
    chk("busy", 64'(busy), 64'(~&e_done));
    chk("protocol_err", 64'(perr), 64'(m_err));
    for (int k = 0; k < N; k++) pop_cnt[k] += int'(pop[k]);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_req();
    need = '0;
    for (int k = 0; k < N; k++) num[k] = '0;
  endtask

  task automatic clear_cnt();
    for (int k = 0; k < N; k++) pop_cnt[k] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    empty = '0;
    ready = '1;
    m_err = 1'b0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    clear_cnt();
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a request presented during reset that must be discarded.
    need[8] = 1'b1; num[8] = 32'd5;
    do_reset();
    clear_req();
    step();

    // Basic: lane 0, three pops.
    clear_cnt();
    need[0] = 1'b1; num[0] = 32'd3;
    step();
    clear_req();
    repeat (5) step();
    chk("basic_pops", 64'(pop_cnt[0]), 64'd3);

    // Broadcast: every lane requests one pop.
    clear_cnt();
    need = '1;
    for (int k = 0; k < N; k++) num[k] = 32'd1;
    step();
    clear_req();
    repeat (3) step();
    for (int k = 0; k < N; k++) chk("bcast_pops", 64'(pop_cnt[k]), 64'd1);

    // Stall: lane 5, empty toggles every cycle.
    clear_cnt();
    need[5] = 1'b1; num[5] = 32'd4;
    empty[5] = 1'b1;
    step();
    clear_req();
    for (int i = 0; i < 12; i++) begin
      empty[5] = ~empty[5];
      step();
    end
    empty[5] = 1'b0;
    chk("stall_pops", 64'(pop_cnt[5]), 64'd4);

    // Zero count, then a second request during a 10-pop burst.
    clear_cnt();
    need[2] = 1'b1; num[2] = 32'd0;
    step();
    clear_req();
    chk("zero_done", 64'(done[2]), 64'd1);
    need[3] = 1'b1; num[3] = 32'd10;
    step();
    clear_req();
    repeat (3) step();
    need[3] = 1'b1; num[3] = 32'd7;
    step();
    clear_req();
    repeat (10) step();
    chk("err_burst_pops", 64'(pop_cnt[3]), 64'd10);
    chk("err_sticky", 64'(perr), 64'd1);

    // Reset mid-burst after 2 of 8 pops.
    clear_cnt();
    need[7] = 1'b1; num[7] = 32'd8;
    step();
    clear_req();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("reset_pops", 64'(pop_cnt[7]), 64'd3);
    chk("reset_done", 64'(done), 64'(~0) & 64'hFFFF_FFFF);
    chk("reset_err", 64'(perr), 64'd0);

    // Last-pop collision on lane 9.
    clear_cnt();
    need[9] = 1'b1; num[9] = 32'd2;
    step();
    clear_req();
    step();
    need[9] = 1'b1; num[9] = 32'd5;
    step();
    clear_req();
    repeat (3) step();
    chk("collide_pops", 64'(pop_cnt[9]), 64'd2);
    chk("collide_idle", 64'(done[9]), 64'd1);
    chk("collide_err", 64'(perr), 64'd1);

    // Maximum count must not wrap to zero.
    do_reset();
    need[1] = 1'b1; num[1] = 32'hFFFF_FFFF;
    step();
    clear_req();
    repeat (20) step();
    chk("maxcnt_busy", 64'(busy), 64'd1);
    do_reset();

    // Randomized traffic across all lanes.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < N; k++) begin
        need[k]  = ($urandom_range(0, 11) == 0);
        num[k]   = W'($urandom_range(0, 6));
        empty[k] = ($urandom_range(0, 3) == 0);
        ready[k] = ($urandom_range(0, 4) != 0);
      end
      step();
    end
    rst = 1'b0;
    clear_req();
    empty = '0;
    ready = '1;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l3c_fifo_pop_ctrl.md
L3C_FIFO_POP_CTRL -- requirements
Module: l3c_fifo_pop_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_FIFO, default 32, setting the number of independently controlled FIFO lanes.
REQ-002 The module SHALL have parameter CNT_W, default 32, setting the width of each pop-count request and remaining counter.
REQ-003 Port clk  input  1  -- single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  -- synchronous, active-high reset.
REQ-005 Port need_pop_matrix_i  input  NUM_FIFO  -- one-cycle request pulse per lane.
REQ-006 Port pop_num_matrix_i  input  CNT_W x NUM_FIFO (unpacked array)  -- pop count per lane, valid in the cycle its need_pop bit is 1.
REQ-007 Port fifo_empty_i  input  NUM_FIFO  -- per-lane FIFO empty flag.
REQ-008 Port pe_ready_i  input  NUM_FIFO  -- per-lane consumer (PE) ready.
REQ-009 Port fifo_pop_o  output  NUM_FIFO  -- per-lane pop strobe; one element removed per asserted cycle.
REQ-010 Port fifo_done_matrix_o  output  NUM_FIFO  -- 1 = lane idle, no pops outstanding.
REQ-011 Port all_done_o  output  1  -- AND of fifo_done_matrix_o.
REQ-012 Port busy_o  output  1  -- OR of lanes in POP.
REQ-013 Port protocol_err_o  output  1  -- sticky flag for a request received while the lane is busy.

Function
REQ-014 Each lane SHALL run an independent two-state FSM: IDLE and POP.
REQ-015 IDLE -> POP SHALL occur on the clock edge where need_pop_matrix_i[k]=1 and pop_num_matrix_i[k]!=0; remain[k] SHALL load pop_num_matrix_i[k] on the same edge.
REQ-016 need_pop_matrix_i[k]=1 with pop_num_matrix_i[k]=0 in IDLE SHALL leave the lane in IDLE, with no pop and done held at 1.
REQ-017 fifo_pop_o[k] SHALL be combinational: 1 iff lane k is in POP, fifo_empty_i[k]=0 and pe_ready_i[k]=1.
REQ-018 Each cycle with fifo_pop_o[k]=1 SHALL decrement remain[k] by 1 on the next edge.
REQ-019 POP -> IDLE SHALL occur on the edge where fifo_pop_o[k]=1 and remain[k]=1; no pop SHALL ever be issued with remain[k]=0.
REQ-020 Empty or not-ready in POP SHALL stall the lane: remain unchanged, no pop, state held.
REQ-021 fifo_done_matrix_o[k] SHALL be a registered decode: 1 when the lane is in IDLE, 0 in POP.
REQ-022 Done SHALL drop in the cycle after the accepted request, so a requester sampling done one cycle after its pulse never sees a stale 1.
REQ-023 need_pop_matrix_i[k]=1 while lane k is in POP SHALL be ignored (remain and state unchanged) and SHALL set protocol_err_o=1 on the next edge.
REQ-024 protocol_err_o SHALL stay set until rst.
REQ-025 A request arriving on the same edge the lane returns to IDLE (last pop) SHALL be treated as arriving in POP: it is ignored and flagged.
REQ-026 Lanes SHALL not interact; any subset may pop in the same cycle.
REQ-027 Counter arithmetic SHALL be unsigned CNT_W bits; a count of 2^CNT_W-1 SHALL be supported without wrap.
REQ-028 all_done_o and busy_o SHALL be combinational reductions of the registered lane states.

Reset
REQ-029 With rst=1 at a clock edge, every lane SHALL go to IDLE, remain SHALL clear to 0 and protocol_err_o SHALL clear to 0.
REQ-030 Reset values after that edge: fifo_done_matrix_o all 1s, all_done_o=1, busy_o=0, fifo_pop_o=0.
REQ-031 Reset asserted mid-POP SHALL abort the outstanding count with no further pops, and the lane SHALL be idle on the next cycle.
REQ-032 Requests presented while rst=1 SHALL be discarded.

Verification
REQ-033 Scenario basic: lane 0 pop_num=3, FIFO non-empty, ready=1 -> fifo_pop_o[0] high exactly 3 consecutive cycles starting one cycle after the request; done[0] 0 for 3 cycles, then 1.
REQ-034 Scenario broadcast: all 32 lanes request pop_num=1 -> each lane pops once in the same cycle; all_done_o returns to 1 two cycles after the request.
REQ-035 Scenario stall: lane 5 pop_num=4, fifo_empty_i[5] toggles 1010... -> exactly 4 pops, only in empty=0 cycles; remain never negative.
REQ-036 Scenario zero count and error: pop_num=0 -> no pop, done stays 1; second request during an active 10-pop burst -> still exactly 10 pops, protocol_err_o=1.
REQ-037 Scenario reset mid-burst: rst asserted after 2 of 8 pops -> no pops from that edge onward, done all 1s, protocol_err_o=0.
REQ-038 Scenario last-pop collision: new request coincides with the final pop -> lane goes to IDLE, request ignored, protocol_err_o=1.
